// File: rtl/vga_sprite_renderer.sv
// Pixel-generation stage behind the VGA timing generator: rebuilds pixel
// coordinates from sync/rdy strobes, draws one square sprite over a flat
// background and keeps sync/DE aligned with the colour output (2-cycle latency).
// Sprite position updates are staged and only take effect on a VSYNC edge.
module vga_sprite_renderer #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned SPRITE_SIZE = 16,
  parameter bit          SYNC_POL    = 1'b1,
  parameter logic [11:0] BG_RGB      = 12'h008,
  parameter logic [11:0] SPRITE_RGB  = 12'hFF0
) (
  input  logic        pxl_clk,
  input  logic        rst,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        rdy,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        pos_valid,
  output logic        pos_ready,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [11:0] rgb_o,
  output logic        frame_start
);

  localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  X_LIM  = 10'(H_ACTIVE - SPRITE_SIZE);
  localparam logic [9:0]  Y_LIM  = 10'(V_ACTIVE - SPRITE_SIZE);
  localparam logic [10:0] SIZE11 = 11'(SPRITE_SIZE);

  typedef enum logic [1:0] {StIdle, StArmed, StCommit} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_x_cnt;
  logic [9:0]  r_y_cnt;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_de1;
  logic        r_hit1;
  logic [9:0]  r_pend_x;
  logic [9:0]  r_pend_y;
  logic [9:0]  r_act_x;
  logic [9:0]  r_act_y;
  logic        r_dirty;
  logic        r_xfer;
  logic        w_vs_edge;
  logic        w_rdy_fall;
  logic        w_xfer;
  logic        w_hit;
  logic [9:0]  w_clamp_x;
  logic [9:0]  w_clamp_y;

  // Stage-1 copies double as the previous-cycle values for edge detection.
  assign w_vs_edge  = (VSYNC == SYNC_POL) && (r_vs1 != SYNC_POL);
  assign w_rdy_fall = r_de1 && !rdy;
  assign w_xfer     = pos_valid && pos_ready;
  assign w_clamp_x  = (pos_x > X_LIM) ? X_LIM : pos_x;
  assign w_clamp_y  = (pos_y > Y_LIM) ? Y_LIM : pos_y;

  // 11-bit compares so active+SPRITE_SIZE cannot wrap at the right/bottom edge.
  assign w_hit = ({1'b0, r_x_cnt} >= {1'b0, r_act_x}) &&
                 ({1'b0, r_x_cnt} <  ({1'b0, r_act_x} + SIZE11)) &&
                 ({1'b0, r_y_cnt} >= {1'b0, r_act_y}) &&
                 ({1'b0, r_y_cnt} <  ({1'b0, r_act_y} + SIZE11));

  // Pixel coordinate counters, saturating so they never wrap mid-frame.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      r_x_cnt <= 10'd0;
      r_y_cnt <= 10'd0;
    end else begin
      if (rdy) begin
        if (r_x_cnt != X_MAX) r_x_cnt <= r_x_cnt + 10'd1;
      end else begin
        r_x_cnt <= 10'd0;
      end
      if (w_vs_edge) begin
        r_y_cnt <= 10'd0;
      end else if (w_rdy_fall && (r_y_cnt != Y_MAX)) begin
        r_y_cnt <= r_y_cnt + 10'd1;
      end
    end
  end

  // Two-stage output pipeline: stage 1 registers strobes and hit, stage 2 colour.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      r_hs1   <= ~SYNC_POL;
      r_vs1   <= ~SYNC_POL;
      r_de1   <= 1'b0;
      r_hit1  <= 1'b0;
      hsync_o <= ~SYNC_POL;
      vsync_o <= ~SYNC_POL;
      de_o    <= 1'b0;
      rgb_o   <= 12'h000;
    end else begin
      r_hs1   <= HSYNC;
      r_vs1   <= VSYNC;
      r_de1   <= rdy;
      r_hit1  <= w_hit;
      hsync_o <= r_hs1;
      vsync_o <= r_vs1;
      de_o    <= r_de1;
      rgb_o   <= r_de1 ? (r_hit1 ? SPRITE_RGB : BG_RGB) : 12'h000;
    end
  end

  // Pending/active position registers; active only changes in the commit cycle.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      r_pend_x <= 10'd0;
      r_pend_y <= 10'd0;
      r_act_x  <= 10'd0;
      r_act_y  <= 10'd0;
      r_dirty  <= 1'b0;
      r_xfer   <= 1'b0;
    end else begin
      r_xfer <= w_xfer;
      if (w_xfer) begin
        r_pend_x <= w_clamp_x;
        r_pend_y <= w_clamp_y;
        r_dirty  <= 1'b1;
      end
      if (r_state == StCommit) begin
        r_act_x <= r_pend_x;
        r_act_y <= r_pend_y;
        r_dirty <= 1'b0;
      end
    end
  end

  // Commit FSM state register.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Commit FSM next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    frame_start  = 1'b0;
    pos_ready    = 1'b1;
    unique case (r_state)
      StIdle: begin
        if (r_dirty) w_state_next = StArmed;
      end
      StArmed: begin
        // Falls back to idle if re-armed with nothing left to commit.
        if (!r_dirty) begin
          w_state_next = StIdle;
        end else if (w_vs_edge) begin
          w_state_next = StCommit;
        end
      end
      StCommit: begin
        frame_start  = 1'b1;
        pos_ready    = 1'b0;
        w_state_next = r_xfer ? StArmed : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Self-checking bench for vga_sprite_renderer using a reduced 80x60 raster.
module tb_vga_sprite_renderer;

  localparam int H     = 80;
  localparam int V     = 60;
  localparam int S     = 16;
  localparam int LINE  = 88;
  localparam int LINES = 64;

  logic        pxl_clk;
  logic        rst;
  logic        HSYNC;
  logic        VSYNC;
  logic        rdy;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        pos_valid;
  logic        pos_ready;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic [11:0] rgb_o;
  logic        frame_start;

  vga_sprite_renderer #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .SPRITE_SIZE(S),
    .SYNC_POL   (1'b1),
    .BG_RGB     (12'h008),
    .SPRITE_RGB (12'hFF0)
  ) dut (
    .pxl_clk    (pxl_clk),
    .rst        (rst),
    .HSYNC      (HSYNC),
    .VSYNC      (VSYNC),
    .rdy        (rdy),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_valid  (pos_valid),
    .pos_ready  (pos_ready),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .de_o       (de_o),
    .rgb_o      (rgb_o),
    .frame_start(frame_start)
  );

  initial pxl_clk = 1'b0;
  always #5 pxl_clk = ~pxl_clk;

  typedef struct {
    logic hs;
    logic vs;
    logic de;
    int   line;
    int   col;
  } ent_t;

  ent_t        hist_q[$];
  logic [11:0] cap [V][H];
  int errors = 0;
  int checks = 0;
  int align_err, blank_err, ready_err, fs_seen, exp_fs;
  int m_pend_x = 0, m_pend_y = 0, m_act_x = 0, m_act_y = 0;
  bit m_dirty = 0;

  function automatic int clampv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Pixels of the captured frame that differ from a sprite drawn at (ax,ay).
  function automatic int bad_pixels(input int ax, input int ay);
    int bad = 0;
    logic [11:0] e;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        e = (c >= ax && c < ax + S && r >= ay && r < ay + S) ? 12'hFF0 : 12'h008;
        if (cap[r][c] !== e) bad++;
      end
    end
    return bad;
  endfunction

  function automatic void sprite_box(output int n, output int x0, output int x1,
                                     output int y0, output int y1);
    n = 0; x0 = 9999; x1 = -1; y0 = 9999; y1 = -1;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        if (cap[r][c] === 12'hFF0) begin
          n++;
          if (c < x0) x0 = c;
          if (c > x1) x1 = c;
          if (r < y0) y0 = r;
          if (r > y1) y1 = r;
        end
      end
    end
  endfunction

  // One pixel clock: observe outputs for the input driven two cycles ago, then drive.
  task automatic tick(input logic hs, input logic vs, input logic de, input int line,
                      input int col, input logic pv, input int px, input int py,
                      input bit ready_exp);
    ent_t e;
    @(negedge pxl_clk);
    if (hist_q.size() == 2) begin
      e = hist_q.pop_front();
      if (hsync_o !== e.hs || vsync_o !== e.vs || de_o !== e.de) align_err++;
      if (e.de && e.line >= 0) cap[e.line][e.col] = rgb_o;
    end
    if (de_o === 1'b0 && rgb_o !== 12'h000) blank_err++;
    if (frame_start === 1'b1) fs_seen++;
    if (pos_ready !== ready_exp) ready_err++;
    HSYNC = hs; VSYNC = vs; rdy = de;
    pos_valid = pv; pos_x = px[9:0]; pos_y = py[9:0];
    if (pv && ready_exp) begin
      m_pend_x = clampv(px, H - S);
      m_pend_y = clampv(py, V - S);
      m_dirty  = 1'b1;
    end
    e.hs = hs; e.vs = vs; e.de = de; e.line = line; e.col = col;
    hist_q.push_back(e);
  endtask

  task automatic run_idle(input int n, input bit pv, input int px, input int py);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, -1, 0, pv && (i == 0), px, py, 1'b1);
  endtask

  // Frame: 2 VSYNC lines, 1 back-porch line, V active lines, 1 front-porch line.
  task automatic run_frame(input int inj_row, input int inj_col, input int ix, input int iy,
                           input bit edge_pv, input int ex, input int ey,
                           input bit cmt_pv, input int cx, input int cy);
    bit committed;
    bit pv;
    bit rexp;
    int px, py, row;
    align_err = 0; blank_err = 0; ready_err = 0; fs_seen = 0; exp_fs = 0;
    committed = 1'b0;
    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) cap[r][c] = 12'hxxx;
    for (int l = 0; l < LINES; l++) begin
      for (int c = 0; c < LINE; c++) begin
        row = (l >= 3 && l < 3 + V) ? l - 3 : -1;
        pv = 1'b0; px = 0; py = 0; rexp = 1'b1;
        if (l == 0 && c == 0 && edge_pv) begin pv = 1'b1; px = ex; py = ey; end
        if (l == 0 && c == 1) begin
          rexp = !committed;
          if (cmt_pv) begin pv = 1'b1; px = cx; py = cy; end
        end
        if (row >= 0 && row == inj_row && c == inj_col) begin pv = 1'b1; px = ix; py = iy; end
        tick(c >= 82 && c < 86, l < 2, row >= 0 && c < H, row, c, pv, px, py, rexp);
        if (l == 0 && c == 0 && m_dirty) begin
          m_act_x = m_pend_x; m_act_y = m_pend_y; m_dirty = 1'b0;
          exp_fs++; committed = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    hist_q.delete();
    @(negedge pxl_clk);
    HSYNC = 1'b1; VSYNC = 1'b1; rdy = 1'b1; pos_valid = 1'b0;
    @(negedge pxl_clk);
    @(negedge pxl_clk);
    checks++;
    if ({de_o, hsync_o, vsync_o, rgb_o} !== {3'b111, 12'hFF0}) begin
      errors++;
      $display("FAIL reset_pre: got de/hs/vs=%b%b%b rgb=%h expected 111 rgb=ff0",
               de_o, hsync_o, vsync_o, rgb_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({de_o, hsync_o, vsync_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_syncs: got de/hs/vs=%b%b%b expected 000", de_o, hsync_o, vsync_o);
    end
    checks++;
    if (rgb_o !== 12'h000) begin
      errors++; $display("FAIL reset_rgb: got %h expected 000", rgb_o);
    end
    checks++;
    if ({pos_ready, frame_start} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake: got ready=%b fs=%b expected ready=1 fs=0",
               pos_ready, frame_start);
    end
    HSYNC = 1'b0; VSYNC = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge pxl_clk);
    rst = 1'b0;
    m_pend_x = 0; m_pend_y = 0; m_act_x = 0; m_act_y = 0; m_dirty = 1'b0;
    repeat (2) @(negedge pxl_clk);
  endtask

  task automatic test_latency();
    bit [7:0] p_rdy = 8'b0000_0001;
    bit [7:0] p_hs  = 8'b0000_0010;
    bit [7:0] p_vs  = 8'b0000_1100;
    logic [2:0] exp;
    hist_q.delete();
    for (int i = 0; i < 9; i++) begin
      @(negedge pxl_clk);
      exp = (i >= 2) ? {p_rdy[i-2], p_hs[i-2], p_vs[i-2]} : 3'b000;
      checks++;
      if ({de_o, hsync_o, vsync_o} !== exp) begin
        errors++;
        $display("FAIL latency_c%0d: got de/hs/vs=%b%b%b expected %b",
                 i, de_o, hsync_o, vsync_o, exp);
      end
      if (i < 8) begin
        rdy = p_rdy[i]; HSYNC = p_hs[i]; VSYNC = p_vs[i];
      end else begin
        rdy = 1'b0; HSYNC = 1'b0; VSYNC = 1'b0;
      end
    end
    hist_q.delete();
  endtask

  task automatic test_sprite_draw();
    int n, x0, x1, y0, y1, bad;
    run_idle(4, 1'b1, 40, 20);
    run_frame(-1, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    sprite_box(n, x0, x1, y0, y1);
    bad = bad_pixels(m_act_x, m_act_y);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL draw_pixels: got %0d bad expected 0", bad); end
    checks++;
    if (n !== 256) begin errors++; $display("FAIL draw_count: got %0d expected 256", n); end
    checks++;
    if ({x0, x1, y0, y1} !== {32'd40, 32'd55, 32'd20, 32'd35}) begin
      errors++;
      $display("FAIL draw_box: got x%0d..%0d y%0d..%0d expected x40..55 y20..35", x0, x1, y0, y1);
    end
    checks++;
    if (fs_seen !== exp_fs) begin
      errors++; $display("FAIL draw_fs: got %0d expected %0d", fs_seen, exp_fs);
    end
    checks++;
    if (align_err !== 0) begin
      errors++; $display("FAIL draw_align: got %0d misaligned expected 0", align_err);
    end
    checks++;
    if (blank_err !== 0) begin
      errors++; $display("FAIL draw_blank: got %0d nonblack expected 0", blank_err);
    end
  endtask

  task automatic test_tear_free();
    int n, x0, x1, y0, y1, bad;
    run_frame(30, 10, 50, 30, 1'b0, 0, 0, 1'b0, 0, 0);
    bad = bad_pixels(40, 20);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL tear_old: got %0d bad expected 0", bad); end
    checks++;
    if (fs_seen !== 0) begin errors++; $display("FAIL tear_fs0: got %0d expected 0", fs_seen); end
    run_frame(-1, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    sprite_box(n, x0, x1, y0, y1);
    bad = bad_pixels(50, 30);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL tear_new: got %0d bad expected 0", bad); end
    checks++;
    if (fs_seen !== 1) begin errors++; $display("FAIL tear_fs1: got %0d expected 1", fs_seen); end
    checks++;
    if ({x0, y0} !== {32'd50, 32'd30}) begin
      errors++; $display("FAIL tear_box: got (%0d,%0d) expected (50,30)", x0, y0);
    end
  endtask

  task automatic test_clamp();
    int n, x0, x1, y0, y1, bad;
    run_idle(4, 1'b1, 900, 700);
    run_idle(4, 1'b1, 79, 59);
    run_frame(-1, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    sprite_box(n, x0, x1, y0, y1);
    bad = bad_pixels(64, 44);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL clamp_pixels: got %0d bad expected 0", bad); end
    checks++;
    if ({x0, x1, y0, y1} !== {32'd64, 32'd79, 32'd44, 32'd59}) begin
      errors++;
      $display("FAIL clamp_box: got x%0d..%0d y%0d..%0d expected x64..79 y44..59", x0, x1, y0, y1);
    end
    checks++;
    if (fs_seen !== 1) begin errors++; $display("FAIL clamp_fs: got %0d expected 1", fs_seen); end
  endtask

  task automatic test_simultaneous();
    int bad;
    run_frame(30, 10, 10, 5, 1'b0, 0, 0, 1'b0, 0, 0);
    run_frame(-1, 0, 0, 0, 1'b1, 20, 40, 1'b1, 60, 10);
    bad = bad_pixels(20, 40);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL simul_edge: got %0d bad expected 0", bad); end
    checks++;
    if (ready_err !== 0) begin
      errors++; $display("FAIL simul_ready: got %0d wrong pos_ready expected 0", ready_err);
    end
    checks++;
    if (fs_seen !== 1) begin errors++; $display("FAIL simul_fs: got %0d expected 1", fs_seen); end
    run_frame(-1, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    bad = bad_pixels(20, 40);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL simul_hold: got %0d bad expected 0", bad); end
    checks++;
    if (fs_seen !== 0) begin
      errors++; $display("FAIL simul_nofs: got %0d expected 0", fs_seen);
    end
    checks++;
    if (blank_err !== 0) begin
      errors++; $display("FAIL simul_blank: got %0d nonblack expected 0", blank_err);
    end
  endtask

  task automatic test_random();
    int rx, ry, bad, n, x0, x1, y0, y1;
    for (int k = 0; k < 2; k++) begin
      rx = int'($urandom_range(0, 1023));
      ry = int'($urandom_range(0, 1023));
      run_idle(4, 1'b1, rx, ry);
      run_frame(-1, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
      sprite_box(n, x0, x1, y0, y1);
      bad = bad_pixels(clampv(rx, H - S), clampv(ry, V - S));
      checks++;
      if (bad !== 0) begin
        errors++; $display("FAIL random_%0d (%0d,%0d): got %0d bad expected 0", k, rx, ry, bad);
      end
      checks++;
      if (n !== 256) begin
        errors++; $display("FAIL random_count_%0d: got %0d expected 256", k, n);
      end
      checks++;
      if (align_err !== 0 || blank_err !== 0 || fs_seen !== 1) begin
        errors++;
        $display("FAIL random_misc_%0d: got align=%0d blank=%0d fs=%0d expected 0 0 1",
                 k, align_err, blank_err, fs_seen);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    HSYNC = 1'b0; VSYNC = 1'b0; rdy = 1'b0;
    pos_valid = 1'b0; pos_x = 10'd0; pos_y = 10'd0;
    repeat (3) @(negedge pxl_clk);
    rst = 1'b0;
    repeat (2) @(negedge pxl_clk);
    test_reset();
    test_latency();
    test_sprite_draw();
    test_tear_free();
    test_clamp();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
